// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data memory) arbiter for a single shared memory port.
// Round-robin on conflict, per-access wait-state timeout, one-cycle done pulse per access.
module mem_port_arbiter #(
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          if_gnt,
  output logic          if_done,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, RESP} state_e;

  // Counter value at which a further not-ready cycle means the TMO-th wait has elapsed.
  localparam logic [3:0] WaitLast = 4'(TMO - 1);

  state_e        state_q;
  logic          last_dm_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic [3:0]    wait_q;

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers; the reset branch clears every flop because the
  // design holds no memory arrays that could be left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_dm_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_req && (!dm_req || last_dm_q)) begin
            state_q   <= GNT_IF;
            addr_q    <= if_addr;
            we_q      <= 1'b0;
            last_dm_q <= 1'b0;
            wait_q    <= '0;
          end else if (dm_req) begin
            state_q   <= GNT_DM;
            addr_q    <= dm_addr;
            we_q      <= dm_we;
            wdata_q   <= dm_wdata;
            last_dm_q <= 1'b1;
            wait_q    <= '0;
          end
        end
        GNT_IF, GNT_DM: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (wait_q == WaitLast) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            wait_q  <= 4'(TMO);
            state_q <= RESP;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode from state only; last_dm_q names the requester just served.
  assign if_gnt    = (state_q == GNT_IF);
  assign dm_gnt    = (state_q == GNT_DM);
  assign mem_en    = if_gnt || dm_gnt;
  assign mem_we    = dm_gnt && we_q;
  assign if_done   = (state_q == RESP) && !last_dm_q;
  assign dm_done   = (state_q == RESP) && last_dm_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: two requester processes, a memory
// responder with random wait states, and a monitor that checks every completion.
module tb_mem_port_arbiter;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int TMO = 15;
  localparam int NTX = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_done, dm_gnt, dm_done, err;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_gnt(if_gnt), .if_done(if_done), .dm_gnt(dm_gnt), .dm_done(dm_done),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            dm;
    logic [DW-1:0] rdata;
    bit            err;
    int            len;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // What the requesters actually asked for; the DUT must present exactly these.
  logic [AW-1:0] if_addr_iss, dm_addr_iss;
  logic [DW-1:0] dm_wdata_iss;
  logic          dm_we_iss;

  // Read-only memory contents: a fixed function of the address.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic mon_en = 1'b0;
  logic rsp_ready = 1'b0;
  assign mem_rdata = rom(mem_addr);
  assign mem_ready = mon_en ? rsp_ready : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)       return $urandom_range(0, 3);
    else if (r < 8)  return $urandom_range(4, TMO - 2);
    else if (r == 8) return $urandom_range(TMO - 1, TMO);
    else             return $urandom_range(TMO, TMO + 5);
  endfunction

  // Monitor + memory responder, evaluated on the falling edge.
  logic          prev_gnt = 0, prev_done = 0, prev_idle = 1, prev_req_if = 0, prev_req_dm = 0;
  logic          last_dm_m = 1'b1;
  logic          win_dm = 1'b0;
  logic          cur_gnt, cur_done;
  logic [DW-1:0] hold_rdata = '0;
  logic          hold_err = 1'b0;
  int            gnt_len = 0, rsp_delay = 0, rsp_k = 0;
  exp_t          e;

  always @(negedge clk) begin
    if (mon_en) begin
      cur_gnt  = if_gnt | dm_gnt;
      cur_done = if_done | dm_done;
      check("gnt_onehot", if_gnt & dm_gnt, 0);
      if (prev_done) check("resp_then_idle", cur_gnt | cur_done, 0);
      if (prev_idle) check("grant_latency", cur_gnt, prev_req_if | prev_req_dm);

      if (cur_gnt && !prev_gnt) begin
        // Conflict goes to whoever was not served last; reset leaves "DM served last".
        win_dm    = (prev_req_if && prev_req_dm) ? !last_dm_m : prev_req_dm;
        last_dm_m = win_dm;
        check("arb_winner", dm_gnt, win_dm);
        rsp_delay = pick_delay();
        rsp_k     = 0;
        gnt_len   = 0;
        e.dm    = win_dm;
        e.err   = (rsp_delay >= TMO);
        e.rdata = e.err ? '0 : rom(win_dm ? dm_addr_iss : if_addr_iss);
        e.len   = e.err ? TMO : rsp_delay + 1;
        sb.push_back(e);
      end

      if (cur_gnt) begin
        gnt_len++;
        check("gnt_holder", dm_gnt, win_dm);
        check("mem_en_gnt", mem_en, 1);
        check("mem_addr", mem_addr, win_dm ? dm_addr_iss : if_addr_iss);
        check("mem_we", mem_we, win_dm & dm_we_iss);
        if (win_dm) check("mem_wdata", mem_wdata, dm_wdata_iss);
        rsp_ready = (rsp_k == rsp_delay);
        rsp_k++;
      end else begin
        check("mem_en_idle", mem_en, 0);
        rsp_ready = 1'($urandom_range(0, 1));
      end

      if (cur_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done_unexpected: got done with empty scoreboard, required none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("done_who", {if_done, dm_done}, e.dm ? 2'b01 : 2'b10);
          check("rdata", rdata, e.rdata);
          check("err", err, e.err);
          check("gnt_len", gnt_len, e.len);
          hold_rdata = e.rdata;
          hold_err   = e.err;
        end
      end else begin
        check("rdata_hold", rdata, hold_rdata);
        check("err_hold", err, hold_err);
      end

      prev_gnt    = cur_gnt;
      prev_done   = cur_done;
      prev_idle   = !cur_gnt && !cur_done;
      prev_req_if = if_req;
      prev_req_dm = dm_req;
    end
  end

  task automatic run_req(input bit is_dm, input int n);
    for (int t = 0; t < n; t++) begin
      int idle;
      bit got;
      idle = $urandom_range(0, 5);
      if (t == 0 || idle > 2) idle = 0;
      repeat (idle) begin @(posedge clk); #1; end
      if (is_dm) begin
        dm_addr      = 16'($urandom);
        dm_wdata     = 16'($urandom);
        dm_we        = 1'($urandom_range(0, 1));
        dm_addr_iss  = dm_addr;
        dm_wdata_iss = dm_wdata;
        dm_we_iss    = dm_we;
        dm_req       = 1'b1;
      end else begin
        if_addr     = 16'($urandom);
        if_addr_iss = if_addr;
        if_req      = 1'b1;
      end
      got = 0;
      for (int c = 0; c < 80 && !got; c++) begin
        @(negedge clk);
        if (is_dm ? dm_done : if_done) got = 1;
        else if ((is_dm ? dm_gnt : if_gnt) && $urandom_range(0, 2) == 0) begin
          // Fields (and occasionally req) wander while granted; the access must not notice.
          @(posedge clk); #1;
          if (is_dm) begin
            dm_addr  = 16'($urandom);
            dm_wdata = 16'($urandom);
            dm_we    = !dm_we;
            if ($urandom_range(0, 3) == 0) dm_req = 1'b0;
          end else begin
            if_addr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) if_req = 1'b0;
          end
        end
      end
      check(is_dm ? "dm_done_wait" : "if_done_wait", got, 1);
      @(posedge clk); #1;
      if (is_dm) dm_req = 1'b0;
      else       if_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit done_seen;
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    if_addr_iss = '0; dm_addr_iss = '0; dm_wdata_iss = '0; dm_we_iss = 0;

    repeat (2) @(negedge clk);
    check("rst_if_gnt", if_gnt, 0);
    check("rst_dm_gnt", dm_gnt, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    // DM write granted, fields disturbed mid-grant, then reset lands during the grant.
    dm_req = 1; dm_we = 1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (dm_gnt) ok = 1;
    end
    check("mid_rst_gnt_seen", ok, 1);
    check("mid_rst_mem_addr", mem_addr, 16'h0100);
    check("mid_rst_mem_we", mem_we, 1);
    check("mid_rst_mem_wdata", mem_wdata, 16'h1234);
    @(posedge clk); #1;
    dm_addr = 16'hFFFF; dm_wdata = 16'h0000; dm_we = 0;
    @(negedge clk);
    check("stable_mem_addr", mem_addr, 16'h0100);
    check("stable_mem_wdata", mem_wdata, 16'h1234);
    check("stable_mem_we", mem_we, 1);
    check("stable_dm_gnt", dm_gnt, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_dm_gnt", dm_gnt, 0);
    dm_req = 0;
    @(posedge clk); #1 rst = 1'b0;
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      done_seen |= dm_done | if_done;
    end
    check("mid_rst_no_done", done_seen, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_idle_mem_en", mem_en, 0);

    // Randomised phase: both requesters start on the same edge to exercise the first conflict.
    @(posedge clk); #1;
    mon_en = 1'b1;
    fork
      run_req(1'b0, NTX);
      run_req(1'b1, NTX);
    join
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DW, 16, data width in bits.
REQ-002 SHALL have parameter AW, 16, address width in bits.
REQ-003 SHALL have parameter TMO, 15, maximum wait cycles for mem_ready before timeout, range 1-15.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports if_req  in  1, if_addr  in  AW: instruction-fetch read request and its address.
REQ-007 SHALL have ports dm_req  in  1, dm_we  in  1, dm_addr  in  AW, dm_wdata  in  DW: data-memory request, write enable, address and write data.
REQ-008 SHALL have ports if_gnt  out  1, if_done  out  1, dm_gnt  out  1, dm_done  out  1: per-requester grant and one-cycle completion pulse.
REQ-009 SHALL have ports rdata  out  DW, err  out  1: read data and timeout flag, both valid only while a done is high.
REQ-010 SHALL have ports mem_en  out  1, mem_we  out  1, mem_addr  out  AW, mem_wdata  out  DW, mem_rdata  in  DW, mem_ready  in  1: single shared memory port.

Function
REQ-011 SHALL implement states IDLE, GNT_IF, GNT_DM, RESP.
REQ-012 IDLE: SHALL sample if_req/dm_req each edge; one request -> grant it; both -> grant the requester not served last (last_dm flag); none -> stay IDLE.
REQ-013 On grant, SHALL latch requester address (and dm_we, dm_wdata for DM; mem_we=0 for IF) into registers, set last_dm accordingly, clear wait counter.
REQ-014 GNT_IF/GNT_DM: SHALL hold mem_en=1, matching gnt=1, and mem_addr/mem_we/mem_wdata from latched registers, unchanged until leaving the state.
REQ-015 SHALL sample mem_ready at each edge in GNT_x; if 1 -> capture mem_rdata into rdata, err<=0, go RESP.
REQ-016 SHALL increment a 4-bit wait counter each GNT_x cycle with mem_ready=0; when counter equals TMO -> rdata<=0, err<=1, go RESP.
REQ-017 RESP: SHALL drive exactly the served requester's done=1 for one cycle, mem_en=0, both gnt=0, ignore requests; next state IDLE unconditionally.
REQ-018 Requesters SHALL hold req and request fields stable until done; SHALL deassert req on the edge done is seen; arbiter behaviour when req is still high in IDLE is a new request.
REQ-019 Minimum latency: req sampled at edge N -> gnt/mem_en high from edge N+1 -> (mem_ready=1 at edge N+2) done high N+2..N+3 -> IDLE at N+3.
REQ-020 Back-to-back: a request pending through RESP SHALL be granted at the first IDLE edge; with both pending, alternation is strict (IF, DM, IF, ...).
REQ-021 rdata and err SHALL hold their value outside RESP; dm write completion SHALL return rdata of mem_rdata as sampled (don't-care to requester).
REQ-022 Request dropped during GNT_x (protocol violation) SHALL NOT abort the access; it completes normally.
REQ-023 Outputs gnt, mem_en, mem_we SHALL be decoded from state only (no combinational path from req inputs).

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, all gnt/done/mem_en/mem_we/err=0, rdata=0, mem_addr=0, mem_wdata=0, last_dm=1 (first conflict goes to IF), wait counter=0.
REQ-025 Reset asserted mid-access SHALL drop mem_en within the same cycle, produce no done, and lose the transaction; requester reissues after reset.

Verification
REQ-026 Single IF read: if_req=1, if_addr=0x0040, mem_ready=1 after 2 wait cycles, mem_rdata=0xBEEF -> if_gnt for 3 cycles, if_done one cycle with rdata=0xBEEF, err=0.
REQ-027 Simultaneous requests after reset: if_req=dm_req=1 same edge -> IF served first, then DM (dm_we=1, dm_addr=0x0100, dm_wdata=0x1234 seen on mem_* with mem_we=1), then IF again if still requesting.
REQ-028 Timeout: dm_req=1, mem_ready held 0 -> dm_done after exactly TMO=15 grant cycles, err=1, rdata=0x0000; next IF request completes normally with err=0.
REQ-029 Zero-wait back-to-back: if_req held, mem_ready=1 always -> if_done every 3rd cycle, mem_en pattern 1,0,0 repeating, mem_addr stable during each grant.
REQ-030 Reset mid-access: rst pulsed in GNT_DM -> mem_en and dm_gnt low in same cycle, no dm_done, state IDLE, rdata=0, err=0 after release.
REQ-031 Field stability: change dm_addr/dm_wdata during GNT_DM -> mem_addr/mem_wdata keep latched values until RESP.
